// File: rtl/mem_io_responder.sv
// CPU-side memory responder: byte RAM plus a small memory-mapped I/O page.
// The I/O page provides rx/tx byte FIFOs, a free-running cycle counter and a stop flag.
module mem_io_responder #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int unsigned RAM_BYTES = 2 ** ADDR_W;
  localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
  localparam int unsigned RX_PW     = RX_AW + 1;
  localparam int unsigned TX_PW     = TX_AW + 1;

  logic [7:0]       ram [RAM_BYTES];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW:0]   rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW:0]   tx_wr_ptr, tx_rd_ptr;
  logic [31:0]      counter;
  logic [23:0]      snap;

  logic             sel_io, io_page, accept;
  logic [2:0]       io_reg;
  logic             rd_rx, wr_tx, wr_stop;
  logic             rx_empty, rx_full, rx_push, rx_pop;
  logic             tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]       tx_push_data;
  logic [7:0]       rd_data;
  logic             unused_addr_bits;

  assign unused_addr_bits = &{1'b0, cpu_a[31:18]};

  // Address decode: bits 17:16 == 2'b11 is the I/O region, the first 8 bytes are registers.
  assign sel_io  = (cpu_a[17:16] == 2'b11);
  assign io_page = sel_io && (cpu_a[15:3] == 13'd0);
  assign io_reg  = cpu_a[2:0];
  assign rd_rx   = io_page && !cpu_wr && (io_reg == 3'd0);
  assign wr_stop = io_page && cpu_wr && (io_reg == 3'd4);
  assign wr_tx   = (io_page && cpu_wr && (io_reg == 3'd0) && (cpu_dout != 8'd0)) || wr_stop;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                    (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);

  // Combinational ready is safe: every CPU bus output is launched from a register.
  assign rdy_out = rst_in && !prog_stop && !(rd_rx && rx_empty) && !(wr_tx && tx_full);
  assign accept  = rdy_out;

  assign rx_ready     = !rx_full;
  assign rx_push      = rx_valid && !rx_full;
  assign rx_pop       = accept && rd_rx;
  assign tx_valid     = !tx_empty;
  assign tx_data      = tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_push      = accept && wr_tx;
  assign tx_push_data = wr_stop ? 8'd0 : cpu_dout;

  always_comb begin
    rd_data = 8'd0;
    if (!sel_io) begin
      rd_data = ram[cpu_a[ADDR_W-1:0]];
    end else if (io_page) begin
      case (io_reg)
        3'd0:    rd_data = rx_mem[rx_rd_ptr[RX_AW-1:0]];
        3'd4:    rd_data = counter[7:0];
        3'd5:    rd_data = snap[7:0];
        3'd6:    rd_data = snap[15:8];
        3'd7:    rd_data = snap[23:16];
        default: rd_data = 8'd0;
      endcase
    end
  end

  // Storage arrays carry no reset; RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (accept && cpu_wr && !sel_io) ram[cpu_a[ADDR_W-1:0]] <= cpu_dout;
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= tx_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      counter   <= 32'd0;
      snap      <= 24'd0;
      prog_stop <= 1'b0;
      cpu_din   <= 8'd0;
    end else begin
      counter <= counter + 32'd1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
      if (accept && !cpu_wr) begin
        cpu_din <= rd_data;
        if (io_page && (io_reg == 3'd4)) snap <= counter[31:8];
      end
      if (accept && wr_stop) prog_stop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned RX_DEPTH = 16;
  localparam int unsigned TX_DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;

  always #5 clk_in = ~clk_in;

  mem_io_responder #(.ADDR_W(ADDR_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .rdy_out(rdy_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_stop(prog_stop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [31:0] cnt_m;
  logic [23:0] snap_m;
  logic        stop_m;
  logic [7:0]  din_m;
  logic        last_acc;
  logic [31:0] pool [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_wr = wr; cpu_a = a; cpu_dout = d;
  endtask

  task automatic idle();
    req(1'b1, 32'h0003_0001, 8'h00);
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step();
    logic [17:0] a18;
    logic        exp_rdy, rx_can, tx_can, is_ram;
    int          idx;
    if (!rst_in) begin
      rxq.delete(); txq.delete();
      cnt_m = 0; snap_m = 0; stop_m = 0; din_m = 0;
    end
    #1;
    a18    = cpu_a[17:0];
    is_ram = (a18 < 18'h30000);
    idx    = int'(cpu_a[ADDR_W-1:0]);
    exp_rdy = rst_in && !stop_m
           && !(!cpu_wr && a18 == 18'h30000 && rxq.size() == 0)
           && !(cpu_wr && ((a18 == 18'h30000 && cpu_dout != 8'h00) || a18 == 18'h30004)
                && txq.size() == TX_DEPTH);
    check("rdy_out", 32'(rdy_out), 32'(exp_rdy));
    check("rx_ready", 32'(rx_ready), 32'(rxq.size() < RX_DEPTH));
    check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
    check("prog_stop", 32'(prog_stop), 32'(stop_m));
    check("cpu_din", 32'(cpu_din), 32'(din_m));
    last_acc = exp_rdy;
    if (rst_in) begin
      rx_can = rx_valid && rxq.size() < RX_DEPTH;
      tx_can = tx_ready && txq.size() != 0;
      if (exp_rdy) begin
        if (is_ram) begin
          if (cpu_wr) ram_m[idx] = cpu_dout;
          else        din_m = ram_m[idx];
        end else if (cpu_wr) begin
          if (a18 == 18'h30000 && cpu_dout != 8'h00) txq.push_back(cpu_dout);
          if (a18 == 18'h30004) begin txq.push_back(8'h00); stop_m = 1'b1; end
        end else begin
          case (a18)
            18'h30000: din_m = rxq.pop_front();
            18'h30004: begin din_m = cnt_m[7:0]; snap_m = cnt_m[31:8]; end
            18'h30005: din_m = snap_m[7:0];
            18'h30006: din_m = snap_m[15:8];
            18'h30007: din_m = snap_m[23:16];
            default:   din_m = 8'h00;
          endcase
        end
      end
      if (tx_can) void'(txq.pop_front());
      if (rx_can) rxq.push_back(rx_data);
      cnt_m = cnt_m + 32'd1;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          ch;
    int          j;
    rst_in = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    idle();
    cnt_m = 0; snap_m = 0; stop_m = 0; din_m = 0; last_acc = 1'b0;
    for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 32'h2FFFF)) | ($urandom << 18);

    // Reset state
    step(); step();
    check("rst_rdy", 32'(rdy_out), 32'd0);
    check("rst_din", 32'(cpu_din), 32'h00);
    rst_in = 1'b1;

    // RAM write then read-back
    req(1'b1, 32'h0000_1234, 8'hA5); step();
    req(1'b0, 32'h0000_1234, 8'h00); step();
    check("ram_rd", 32'(cpu_din), 32'hA5);
    idle(); step();

    // Read stalls on empty rx, then completes once a byte arrives
    req(1'b0, 32'h0003_0000, 8'h00); step();
    check("rx_stall", 32'(rdy_out), 32'd0);
    rx_valid = 1'b1; rx_data = 8'h41; step();
    rx_valid = 1'b0; step();
    check("rx_rd", 32'(cpu_din), 32'h41);
    idle(); step();

    // Zero write ignored; fill tx and stall until the sink drains one byte
    req(1'b1, 32'h0003_0000, 8'h00); step();
    req(1'b1, 32'h0003_0000, 8'h48); step();
    check("tx_first", 32'(tx_data), 32'h48);
    for (int i = 0; i < TX_DEPTH - 1; i++) begin
      req(1'b1, 32'h0003_0000, 8'(i + 1)); step();
    end
    req(1'b1, 32'h0003_0000, 8'hEE); step(); step();
    check("tx_full_stall", 32'(rdy_out), 32'd0);
    tx_ready = 1'b1; step();
    tx_ready = 1'b0; step();
    check("tx_after_pop", 32'(tx_data), 32'h01);
    idle(); tx_ready = 1'b1;
    repeat (TX_DEPTH + 2) step();
    check("tx_drained", 32'(tx_valid), 32'd0);

    // Coherent 32-bit counter read at 0x1FF
    rst_in = 1'b0; step(); rst_in = 1'b1;
    for (int k = 0; k < 1000 && cnt_m != 32'h1FF; k++) step();
    req(1'b0, 32'h0003_0004, 8'h00); step(); check("cnt_b0", 32'(cpu_din), 32'hFF);
    req(1'b0, 32'h0003_0005, 8'h00); step(); check("cnt_b1", 32'(cpu_din), 32'h01);
    req(1'b0, 32'h0003_0006, 8'h00); step(); check("cnt_b2", 32'(cpu_din), 32'h00);
    req(1'b0, 32'h0003_0007, 8'h00); step(); check("cnt_b3", 32'(cpu_din), 32'h00);
    idle(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rx_valid = ($urandom_range(0, 4) < 2);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 1) == 1);
      if (last_acc) begin
        ch = int'($urandom_range(0, 9));
        j  = int'($urandom_range(0, 7));
        a  = {14'($urandom), 18'h00000};
        case (ch)
          0, 1: req(1'b1, pool[j], 8'($urandom));
          2, 3: if (ram_m.exists(int'(pool[j][ADDR_W-1:0]))) req(1'b0, pool[j], 8'($urandom));
                else req(1'b1, pool[j], 8'($urandom));
          4: req(1'b0, a | 32'h30000, 8'($urandom));
          5: req(1'b1, a | 32'h30000, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
          6: req(1'b0, a | (32'h30004 + $urandom_range(0, 3)), 8'($urandom));
          7: if ($urandom_range(0, 1) == 1) req(1'b0, a | (32'h30001 + $urandom_range(0, 2)), 8'($urandom));
             else req(1'b0, a | 32'h30000 | $urandom_range(8, 32'hFFFF), 8'($urandom));
          8: req(1'b1, a | (($urandom_range(0, 1) == 1) ? (32'h30001 + $urandom_range(0, 2))
                                                         : (32'h30005 + $urandom_range(0, 2))), 8'($urandom));
          default: idle();
        endcase
      end
      step();
    end
    rx_valid = 1'b0;

    // Stop: emits 0x00, sets the flag and freezes the bus until reset
    idle(); tx_ready = 1'b1;
    repeat (TX_DEPTH + 2) step();
    tx_ready = 1'b0;
    req(1'b1, 32'h0003_0004, 8'h77); step();
    check("stop_flag", 32'(prog_stop), 32'd1);
    check("stop_byte", 32'(tx_data), 32'h00);
    idle(); step(); step();
    check("stop_hold", 32'(rdy_out), 32'd0);
    rst_in = 1'b0; step();
    check("stop_clr", 32'(prog_stop), 32'd0);
    check("stop_din", 32'(cpu_din), 32'h00);
    check("stop_txv", 32'(tx_valid), 32'd0);

    // Reset while stalled on an empty rx read, then a clean transfer
    rst_in = 1'b1;
    req(1'b0, 32'h0003_0000, 8'h00); step(); step();
    rst_in = 1'b0; step();
    rst_in = 1'b1; step();
    rx_valid = 1'b1; rx_data = 8'h55; step();
    rx_valid = 1'b0; step();
    check("post_rst_rx", 32'(cpu_din), 32'h55);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus: 128 KB byte RAM plus the memory-mapped I/O block at 0x30000–0x30007.
- Drives the CPU's data-in bus and its `rdy` pause input.
- Stalls the CPU when I/O buffering cannot accept or supply a byte.
- Sits at the top level between the CPU core and the UART/host byte streams.

Parameters:
- ADDR_W, 17, RAM address width; RAM holds 2^ADDR_W bytes, indexed by cpu_a[ADDR_W-1:0].
- RX_DEPTH, 16, input FIFO depth in bytes; power of two, ≥2.
- TX_DEPTH, 16, output FIFO depth in bytes; power of two, ≥2.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- cpu_a  input  32  byte address from the CPU; only bits 17:0 are decoded.
- cpu_wr  input  1  1 = write, 0 = read.
- cpu_dout  input  8  write data from the CPU.
- cpu_din  output  8  registered read data to the CPU.
- rdy_out  output  1  CPU ready; low pauses the CPU.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  input FIFO accepts a byte.
- tx_data  output  8  outgoing byte (head of the output FIFO).
- tx_valid  output  1  output FIFO not empty.
- tx_ready  input  1  sink accepts tx_data.
- prog_stop  output  1  sticky; program has signalled stop.

Behaviour:
- Request acceptance:
  - A request is accepted in every cycle where rst_in=1 and rdy_out=1.
  - No request is acted on while rdy_out=0; the CPU holds cpu_a, cpu_wr and cpu_dout stable while paused.
- Address decode:
  - cpu_a[17:16]==2'b11 selects I/O.
  - Any other value selects RAM at cpu_a[ADDR_W-1:0].
- RAM read: cpu_din shows the addressed byte on the cycle after acceptance (one-cycle registered latency).
- RAM write: the byte is stored at the accepting edge. A read of the same address in the next cycle returns the new byte.
- cpu_din update rule: cpu_din updates only on accepted reads. It holds its value otherwise, including during stalls.
- I/O read 0x30000:
  - Pops the input FIFO; cpu_din = popped byte next cycle.
  - If the FIFO is empty, rdy_out=0 until it becomes non-empty; the pop then occurs.
- I/O write 0x30000:
  - cpu_dout!=0: pushes into the output FIFO. If the FIFO is full, rdy_out=0 until space frees.
  - cpu_dout==0: ignored, no stall.
- Cycle counter: a 32-bit counter increments every clk_in cycle after reset release, wraps at 2^32, and is not affected by rdy_out.
- I/O read 0x30004:
  - cpu_din = counter[7:0].
  - Simultaneously latches counter[31:8] into a snapshot register.
- I/O read 0x30005/6/7: return snapshot bytes [15:8], [23:16], [31:24] respectively. This makes a 4-byte read of 0x30004 coherent.
- I/O write 0x30004 (stop):
  - Pushes 0x00 into the output FIFO, stalling if full.
  - On acceptance, prog_stop=1.
  - Afterwards rdy_out stays 0 permanently until reset.
- Other I/O addresses: reads return 0x00; writes are ignored.
- rdy_out is combinational and equals the AND of:
  - rst_in
  - !prog_stop
  - !(I/O read 0x30000 && rx empty)
  - !(I/O write to 0x30000 with nonzero data, or to 0x30004, && tx full)
  - The combinational path is legal because CPU bus outputs are registered.
- Input FIFO:
  - rx_ready = !rx_full.
  - Push when rx_valid && rx_ready.
  - Push and pop in the same cycle are both honoured. A push when full is impossible.
- Output FIFO:
  - tx_valid = !tx_empty; pop when tx_valid && tx_ready.
  - A push to a full FIFO in the same cycle as a pop still stalls, because full is evaluated before the pop.
  - FIFO pointers wrap modulo depth; full/empty are tracked with an extra pointer bit.
- Reset (asynchronous, any time, including mid-stall):
  - Clears both FIFOs, the counter, the snapshot and prog_stop; cpu_din=0x00.
  - Outputs during reset: rdy_out=0, rx_ready=1, tx_valid=0, tx_data=don't-care.
  - RAM contents are not cleared.
  - Any stalled request is dropped.

Test Plan:
- Write 0xA5 to 0x01234, then read 0x01234 -> cpu_din=0xA5 one cycle after the read; rdy_out stays 1.
- Read 0x30000 with rx empty -> rdy_out=0. Drive rx_data=0x41 with rx_valid for one cycle -> the FIFO pops the byte, rdy_out=1, and cpu_din=0x41 on the following cycle.
- Write 0x00 then 0x48 to 0x30000 -> only 0x48 appears on tx_data/tx_valid. Fill TX_DEPTH bytes with tx_ready=0, then write once more -> rdy_out=0 until tx_ready=1 for one cycle.
- At counter=0x000001FF, read 0x30004..0x30007 over 4 accepted cycles -> bytes FF,01,00,00, unchanged by counter advance between reads.
- Write 0x30004 -> tx emits 0x00, prog_stop=1, rdy_out held 0. Assert rst_in=0 -> prog_stop=0, FIFOs empty, cpu_din=0x00.
- Assert reset while stalled on an rx-empty read, release, then push and pop 0x55 -> reads 0x55 with no stale data.
